control_sequencer: RTL and testbench

- Hardwired Moore control unit sitting directly upstream of DataPath.
- Generates the per-step control strobes that DataPath consumes: PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, Zlowout, register select/enable and the 5-bit ALU opcode.
- Executes instruction fetch followed by three-register ALU instructions (ra <- rb OP rc), e.g. rol R4, R3, R7.

---
 rtl/control_sequencer.sv | 164 ++++++++++++++++
 tb/tb_control_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit that sequences instruction fetch and
// three-register ALU instructions (ra <- rb OP rc) for the DataPath.
`timescale 1ns/1ps
module control_sequencer #(
  parameter int          MEM_TIMEOUT = 8,
  parameter logic [4:0]  OPC_MAX     = 5'b01000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        Zlowout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  opcode,
  output logic        busy,
  output logic        fault
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE, T0, T1, T2, T3, T4, T5, FAULT
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] tmo_cnt;
  logic          illegal_op;
  logic          unused_ir;

  // Register fields IR[26:15] are decoded by DataPath, not here.
  assign unused_ir  = ^IR[26:0];
  assign illegal_op = (IR[31:27] > OPC_MAX);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    next_state = state;
    case (state)
      IDLE:    if (run) next_state = T0;
      T0:      next_state = T1;
      T1: begin
        if (mem_ready)
          next_state = T2;
        else if (tmo_cnt == CW'(MEM_TIMEOUT - 1))
          next_state = FAULT;
      end
      T2:      next_state = T3;
      T3:      next_state = illegal_op ? FAULT : T4;
      T4:      next_state = T5;
      T5:      next_state = run ? T0 : IDLE;
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: strobes are decoded from next_state and registered, so each step's
  // controls are glitch-free and valid for the whole cycle spent in that step.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      PCout   <= 1'b0;
      PCin    <= 1'b0;
      IncPC   <= 1'b0;
      MARin   <= 1'b0;
      Read    <= 1'b0;
      MDRin   <= 1'b0;
      MDRout  <= 1'b0;
      IRin    <= 1'b0;
      Yin     <= 1'b0;
      ZLowIn  <= 1'b0;
      Zlowout <= 1'b0;
      Gra     <= 1'b0;
      Grb     <= 1'b0;
      Grc     <= 1'b0;
      Rin     <= 1'b0;
      Rout    <= 1'b0;
      opcode  <= 5'b00000;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state <= next_state;

      if (next_state == T1 && state != T1)
        tmo_cnt <= '0;
      else if (state == T1)
        tmo_cnt <= tmo_cnt + 1'b1;

      PCout   <= 1'b0;
      PCin    <= 1'b0;
      IncPC   <= 1'b0;
      MARin   <= 1'b0;
      Read    <= 1'b0;
      MDRin   <= 1'b0;
      MDRout  <= 1'b0;
      IRin    <= 1'b0;
      Yin     <= 1'b0;
      ZLowIn  <= 1'b0;
      Zlowout <= 1'b0;
      Gra     <= 1'b0;
      Grb     <= 1'b0;
      Grc     <= 1'b0;
      Rin     <= 1'b0;
      Rout    <= 1'b0;
      opcode  <= 5'b00000;
      busy    <= (next_state != IDLE) && (next_state != FAULT);
      fault   <= (next_state == FAULT);

      case (next_state)
        T0: begin
          PCout <= 1'b1;
          MARin <= 1'b1;
          IncPC <= 1'b1;
          PCin  <= 1'b1;
        end
        T1: begin
          Read  <= 1'b1;
          MDRin <= 1'b1;
        end
        T2: begin
          MDRout <= 1'b1;
          IRin   <= 1'b1;
        end
        T3: begin
          // An illegal opcode heads to FAULT from T3 without touching operands.
          if (!illegal_op) begin
            Grc  <= 1'b1;
            Rout <= 1'b1;
            Yin  <= 1'b1;
          end
        end
        T4: begin
          Grb    <= 1'b1;
          Rout   <= 1'b1;
          ZLowIn <= 1'b1;
          opcode <= IR[31:27];
        end
        T5: begin
          Zlowout <= 1'b1;
          Gra     <= 1'b1;
          Rin     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: instruction-level stimulus pushes the
// expected strobe set per cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam int         MEM_TIMEOUT = 8;
  localparam logic [4:0] OPC_MAX     = 5'b01000;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] IR = '0;
  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic Yin, ZLowIn, Zlowout, Gra, Grb, Grc, Rin, Rout, busy, fault;
  logic [4:0] opcode;

  always #5 clock = ~clock;

  control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .OPC_MAX(OPC_MAX)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .ZLowIn(ZLowIn), .Zlowout(Zlowout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .opcode(opcode), .busy(busy), .fault(fault)
  );

  typedef struct packed {
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic Yin, ZLowIn, Zlowout, Gra, Grb, Grc, Rin, Rout;
    logic [4:0] opcode;
    logic busy, fault;
  } ctl_t;

  // Instruction steps as the control table lists them.
  typedef enum {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T3_BAD, S_T4, S_T5, S_FAULT} step_e;

  ctl_t act;
  always_comb act = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                     Yin, ZLowIn, Zlowout, Gra, Grb, Grc, Rin, Rout,
                     opcode, busy, fault};

  int    n_tests = 0;
  int    n_fail  = 0;
  ctl_t  exp_q[$];
  string name_q[$];

  task automatic check(input string name, input ctl_t got, input ctl_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic ctl_t vec(input step_e s, input logic [4:0] op);
    ctl_t v = '0;
    case (s)
      S_T0:     begin v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.PCin = 1; v.busy = 1; end
      S_T1:     begin v.Read = 1; v.MDRin = 1; v.busy = 1; end
      S_T2:     begin v.MDRout = 1; v.IRin = 1; v.busy = 1; end
      S_T3:     begin v.Grc = 1; v.Rout = 1; v.Yin = 1; v.busy = 1; end
      S_T3_BAD: v.busy = 1;
      S_T4:     begin v.Grb = 1; v.Rout = 1; v.ZLowIn = 1; v.opcode = op; v.busy = 1; end
      S_T5:     begin v.Zlowout = 1; v.Gra = 1; v.Rin = 1; v.busy = 1; end
      S_FAULT:  v.fault = 1;
      default:  ;
    endcase
    return v;
  endfunction

  function automatic logic rn();
    return 1'($urandom_range(0, 1));
  endfunction

  // Monitor: each negedge compares the DUT against the oldest pending expectation.
  always @(negedge clock) begin : monitor
    ctl_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, act, e);
    end
  end

  // Inputs for the next rising edge, plus the outputs expected after it.
  task automatic drive(input logic r, input logic rdy, input step_e s,
                       input logic [4:0] op, input string name);
    @(negedge clock);
    #1;
    run       = r;
    mem_ready = rdy;
    exp_q.push_back(vec(s, op));
    name_q.push_back(name);
  endtask

  task automatic do_reset(input string name);
    @(negedge clock);
    #1;
    run   = 1'b0;
    clear = 1'b0;
    #1;
    check(name, act, '0);
    #2;
    clear = 1'b1;
  endtask

  // One instruction: k idle cycles (run low), then fetch, wait w cycles for
  // memory (w >= MEM_TIMEOUT means never ready), then execute.
  task automatic instr(input int k, input logic [31:0] ir, input int w,
                       output logic faulted);
    logic [4:0] op;
    op = ir[31:27];
    IR = ir;
    faulted = 1'b0;
    for (int i = 0; i < k; i++) drive(1'b0, rn(), S_IDLE, 5'd0, "idle");
    drive(1'b1, rn(), S_T0, 5'd0, "T0 fetch");
    drive(rn(), 1'b0, S_T1, 5'd0, "T1 read");
    for (int j = 0; j < MEM_TIMEOUT; j++) begin
      if (j == w) begin
        drive(rn(), 1'b1, S_T2, 5'd0, "T2 ir load");
        break;
      end else if (j == MEM_TIMEOUT - 1) begin
        drive(rn(), 1'b0, S_FAULT, 5'd0, "mem timeout");
        faulted = 1'b1;
      end else begin
        drive(rn(), 1'b0, S_T1, 5'd0, "T1 wait");
      end
    end
    if (faulted) return;
    if (op > OPC_MAX) begin
      drive(rn(), rn(), S_T3_BAD, 5'd0, "T3 illegal");
      drive(rn(), rn(), S_FAULT, 5'd0, "illegal fault");
      faulted = 1'b1;
      return;
    end
    drive(rn(), rn(), S_T3, 5'd0, "T3 rc");
    drive(rn(), rn(), S_T4, op, "T4 alu");
    drive(rn(), rn(), S_T5, 5'd0, "T5 writeback");
  endtask

  task automatic hold_fault_then_reset();
    for (int i = 0; i < 3; i++) drive(rn(), rn(), S_FAULT, 5'd0, "fault sticky");
    do_reset("reset clears fault");
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  initial begin : stim
    logic f;
    logic [31:0] ir;
    int w;
    logic [4:0] op;

    #1;
    check("reset state", act, '0);
    #3;
    clear = 1'b1;

    // rol R4, R3, R7 twice back to back, then a 3-cycle memory wait.
    instr(1, 32'h421B8000, 0, f);
    instr(0, 32'h421B8000, 0, f);
    instr(0, 32'h421B8000, 3, f);
    // Memory never answers.
    instr(2, 32'h421B8000, MEM_TIMEOUT, f);
    if (f) hold_fault_then_reset();
    // Illegal opcode 11111.
    instr(1, 32'hF8000000, 0, f);
    if (f) hold_fault_then_reset();
    // Boundary opcodes: highest legal, then lowest illegal.
    instr(1, 32'h40000000, 7, f);
    instr(2, 32'h48000000, 1, f);
    if (f) hold_fault_then_reset();

    // Reset in the middle of T4.
    IR = 32'h421B8000;
    drive(1'b0, 1'b0, S_IDLE, 5'd0, "idle");
    drive(1'b1, 1'b0, S_T0, 5'd0, "T0 fetch");
    drive(1'b0, 1'b0, S_T1, 5'd0, "T1 read");
    drive(1'b0, 1'b1, S_T2, 5'd0, "T2 ir load");
    drive(1'b0, 1'b0, S_T3, 5'd0, "T3 rc");
    @(negedge clock);
    #1;
    run = 1'b0;
    @(posedge clock);
    #1;
    check("T4 before reset", act, vec(S_T4, 5'b01000));
    clear = 1'b0;
    #1;
    check("reset mid-T4", act, '0);
    #1;
    clear = 1'b1;
    instr(2, 32'h421B8000, 0, f);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      w  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 2))
                                      : int'($urandom_range(0, MEM_TIMEOUT));
      op = ($urandom_range(0, 15) < 13) ? 5'($urandom_range(0, 8))
                                        : 5'($urandom_range(9, 31));
      ir = {op, 27'($urandom)};
      instr(int'($urandom_range(0, 2)), ir, w, f);
      if (f) hold_fault_then_reset();
    end

    drive(1'b0, 1'b0, S_IDLE, 5'd0, "final idle");
    @(negedge clock);
    @(negedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
